// File: rtl/flip_flop_bank.sv
// Multi-channel set/clear/toggle flag bank with per-channel HOLD, TIMED
// and TRIGGER modes, registered edge pulses and population summaries.
package common_p;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;
endpackage

module flip_flop_bank
  import common_p::*;
#(
  parameter int CHANNELS = 8,
  parameter int TIMEOUT  = 4
) (
  input  clk_dom_s                       clk_dom_i,
  input  logic                           async_rst_n,
  input  logic [CHANNELS-1:0]            clear_en,
  input  logic [CHANNELS-1:0]            set_en,
  input  logic [CHANNELS-1:0]            toggle_en,
  input  logic [2*CHANNELS-1:0]          mode_i,
  output logic [CHANNELS-1:0]            state_o,
  output logic [CHANNELS-1:0]            rise_o,
  output logic [CHANNELS-1:0]            fall_o,
  output logic                           any_o,
  output logic                           all_o,
  output logic [$clog2(CHANNELS+1)-1:0]  count_o
);

  localparam int CW = $clog2(CHANNELS+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] M_TIMED = 2'b01;
  localparam logic [1:0] M_TRIG  = 2'b10;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT-1);

  logic clk;
  logic clk_en;
  logic unused_sync_rst;

  assign clk             = clk_dom_i.clk;
  assign clk_en          = clk_dom_i.clk_en;
  assign unused_sync_rst = clk_dom_i.sync_rst;

  logic [CHANNELS-1:0]         state_q;
  logic [CHANNELS-1:0]         state_d;
  logic [CHANNELS-1:0]         hist_q;
  logic [CHANNELS-1:0][TW-1:0] timer_q;
  logic [CHANNELS-1:0][TW-1:0] timer_d;
  logic [CHANNELS-1:0]         timed;
  logic [CHANNELS-1:0]         eset;
  logic [CW-1:0]               count_d;

  always_comb begin
    timed = '0;
    eset  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      timed[i] = (mode_i[2*i +: 2] == M_TIMED);
      eset[i]  = set_en[i] &
                 ~((mode_i[2*i +: 2] == M_TRIG) & hist_q[i]);
    end
  end

  // toggle maps to ~state in every mode: it also arms a low TIMED channel
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (clk_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        timer_d[i] = '0;
        if (clear_en[i]) begin
          state_d[i] = 1'b0;
        end else if (eset[i]) begin
          state_d[i] = 1'b1;
        end else if (toggle_en[i]) begin
          state_d[i] = ~state_q[i];
        end else if (timed[i] && state_q[i]) begin
          if (timer_q[i] == T_LAST) begin
            state_d[i] = 1'b0;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_d = count_d + CW'(state_d[i]);
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= '0;
      timer_q <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (clk_en) begin
        hist_q <= set_en;
      end
    end
  end

  // Summaries follow next-state every edge so they line up with state_o
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rise_o  <= '0;
      fall_o  <= '0;
      any_o   <= 1'b0;
      all_o   <= 1'b0;
      count_o <= '0;
    end else begin
      rise_o  <= state_d & ~state_q;
      fall_o  <= ~state_d & state_q;
      any_o   <= |state_d;
      all_o   <= &state_d;
      count_o <= count_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_flip_flop_bank.sv
// Scoreboard bench for flip_flop_bank: directed scenarios plus random
// traffic compared against a countdown-based behavioural model.
module tb_flip_flop_bank;
  import common_p::*;

  localparam int N  = 8;
  localparam int TO = 4;
  localparam int CW = $clog2(N+1);

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  clk_dom_s cd;
  logic [N-1:0]   clear_en = '0;
  logic [N-1:0]   set_en = '0;
  logic [N-1:0]   toggle_en = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0]   state_o;
  logic [N-1:0]   rise_o;
  logic [N-1:0]   fall_o;
  logic           any_o;
  logic           all_o;
  logic [CW-1:0]  count_o;

  always_comb begin
    cd.clk      = clk;
    cd.clk_en   = clk_en;
    cd.sync_rst = 1'b0;
  end

  always #5 clk = ~clk;

  flip_flop_bank #(.CHANNELS(N), .TIMEOUT(TO)) dut (
    .clk_dom_i   (cd),
    .async_rst_n (rst_n),
    .clear_en    (clear_en),
    .set_en      (set_en),
    .toggle_en   (toggle_en),
    .mode_i      (mode),
    .state_o     (state_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .any_o       (any_o),
    .all_o       (all_o),
    .count_o     (count_o)
  );

  typedef struct {
    logic [N-1:0]  st;
    logic [N-1:0]  ri;
    logic [N-1:0]  fa;
    logic          an;
    logic          al;
    logic [CW-1:0] cn;
    int            id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int nstep = 0;

  bit [N-1:0] mst;
  bit [N-1:0] mhist;
  int left[N];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mst = '0;
    mhist = '0;
    for (int i = 0; i < N; i++) left[i] = TO - 1;
  endtask

  // left[i] = further enabled cycles a TIMED channel stays high
  task automatic step(input logic [N-1:0] c, input logic [N-1:0] s,
                      input logic [N-1:0] t, input logic [2*N-1:0] m,
                      input logic en);
    bit [N-1:0] old;
    logic [1:0] md;
    bit tmd;
    bit trg;
    bit eff;
    exp_t e;
    @(negedge clk);
    clear_en = c;
    set_en = s;
    toggle_en = t;
    mode = m;
    clk_en = en;
    old = mst;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        md = m[2*i +: 2];
        tmd = (md == 2'b01);
        trg = (md == 2'b10);
        eff = s[i] && !(trg && mhist[i]);
        if (c[i]) begin
          mst[i] = 1'b0;
        end else if (eff || (t[i] && !mst[i])) begin
          mst[i] = 1'b1;
          left[i] = TO - 1;
        end else if (t[i]) begin
          mst[i] = 1'b0;
        end else if (tmd && mst[i]) begin
          if (left[i] == 0) mst[i] = 1'b0;
          else left[i]--;
        end
        if (!tmd) left[i] = TO - 1;
        mhist[i] = s[i];
      end
    end
    e.st = mst;
    e.ri = mst & ~old;
    e.fa = ~mst & old;
    e.an = |mst;
    e.al = &mst;
    e.cn = CW'($countones(mst));
    e.id = nstep++;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [2*N-1:0] m);
    repeat (n) step('0, '0, '0, m, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_any"}, 32'(any_o), 0);
    chk({tag, "_all"}, 32'(all_o), 0);
    chk({tag, "_rise"}, 32'(rise_o), 0);
    chk({tag, "_fall"}, 32'(fall_o), 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("state@%0d", e.id), 32'(state_o), 32'(e.st));
        chk($sformatf("rise@%0d", e.id), 32'(rise_o), 32'(e.ri));
        chk($sformatf("fall@%0d", e.id), 32'(fall_o), 32'(e.fa));
        chk($sformatf("any@%0d", e.id), 32'(any_o), 32'(e.an));
        chk($sformatf("all@%0d", e.id), 32'(all_o), 32'(e.al));
        chk($sformatf("count@%0d", e.id), 32'(count_o), 32'(e.cn));
      end
    end
  end

  initial begin
    logic [2*N-1:0] rm;
    model_reset();
    #12;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // all flags set, then async reset between edges
    step('0, '1, '0, '0, 1'b1);
    idle(1, '0);
    @(posedge clk);
    #3;
    clear_en = '0;
    set_en = '0;
    toggle_en = '0;
    clk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // HOLD priority and toggle pulses
    step(8'h01, 8'h01, 8'h00, '0, 1'b1);
    step(8'h00, 8'h02, 8'h02, '0, 1'b1);
    step(8'h00, 8'h00, 8'h04, '0, 1'b1);
    step(8'h00, 8'h00, 8'h04, '0, 1'b1);
    step(8'h07, 8'h07, 8'h07, '0, 1'b1);
    idle(1, '0);

    // TIMED ch3: single arm, then retrigger at cycle 2
    step(8'h00, 8'h08, 8'h00, 16'h0040, 1'b1);
    idle(6, 16'h0040);
    step(8'h00, 8'h08, 8'h00, 16'h0040, 1'b1);
    idle(1, 16'h0040);
    step(8'h00, 8'h08, 8'h00, 16'h0040, 1'b1);
    idle(7, 16'h0040);

    // TRIGGER ch4: held set fires once, clear mid-hold sticks
    step(8'h10, 8'h00, 8'h00, 16'h0200, 1'b1);
    repeat (5) step(8'h00, 8'h10, 8'h00, 16'h0200, 1'b1);
    step(8'h10, 8'h10, 8'h00, 16'h0200, 1'b1);
    repeat (3) step(8'h00, 8'h10, 8'h00, 16'h0200, 1'b1);
    idle(1, 16'h0200);
    step(8'h00, 8'h10, 8'h00, 16'h0200, 1'b1);
    step(8'h10, 8'h00, 8'h00, 16'h0200, 1'b1);

    // TIMED ch3 with clk_en gaps
    step(8'h00, 8'h08, 8'h00, 16'h0040, 1'b1);
    step(8'h00, 8'h00, 8'h00, 16'h0040, 1'b0);
    step(8'h00, 8'h00, 8'h00, 16'h0040, 1'b1);
    step(8'h00, 8'h00, 8'h00, 16'h0040, 1'b0);
    step(8'h00, 8'h00, 8'h00, 16'h0040, 1'b0);
    idle(5, 16'h0040);

    // fill all channels one per cycle
    step('1, '0, '0, '0, 1'b1);
    for (int i = 0; i < N; i++) step('0, N'(1 << i), '0, '0, 1'b1);
    idle(1, '0);
    step('1, '0, '0, '0, 1'b1);

    // random traffic with occasional mode changes
    rm = '0;
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) rm = (2*N)'($urandom);
      step(N'($urandom & $urandom & $urandom),
           N'($urandom & $urandom),
           N'($urandom & $urandom & $urandom),
           rm, ($urandom_range(0, 4) != 0));
    end
    idle(2, rm);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
